// File: rtl/nco_pkg.sv
// Shared defaults and index helpers for the sine NCO and its quarter-wave table.
package nco_pkg;

  localparam int BITSIZE_D  = 24;
  localparam int PHASE_D    = 16;
  localparam int TABLE_D    = 9;
  localparam int GAIN_W_D   = 8;
  localparam int UNITY_GAIN = 1 << GAIN_W_D;

  // Table index occupies phase bits [phase_w-3 : phase_w-table_w-2].
  localparam int IDX_MSB_D  = PHASE_D - 3;
  localparam int IDX_LSB_D  = PHASE_D - TABLE_D - 2;

  function automatic int idx_msb(input int phase_w);
    return phase_w - 3;
  endfunction

  function automatic int idx_lsb(input int phase_w, input int table_w);
    return phase_w - table_w - 2;
  endfunction

endpackage

// File: rtl/sine_nco_quarter_rom.sv
// Quarter-wave magnitude table with a single registered read port (BRAM-friendly).
module quarter_rom #(
  parameter int TABLE      = 9,
  parameter int BITSIZE    = 24,
  parameter     TABLE_FILE = "testtable.hex",
  parameter bit RAMP_TABLE = 1'b0
) (
  input  logic               clk,
  input  logic [TABLE-1:0]   addr,
  output logic [BITSIZE-1:0] data
);

  generate
    if (RAMP_TABLE) begin : g_ramp
      // Built-in ramp (entry i = i) for bring-up without an init file.
      always_ff @(posedge clk) begin
        data <= BITSIZE'(addr);
      end
    end else begin : g_file
      logic [BITSIZE-1:0] r_mem [0:(2**TABLE)-1];

      initial begin
        real amp;
        real ang;
        amp = (2.0 ** (BITSIZE - 1)) - 1.0;
        for (int unsigned i = 0; i < (2**TABLE); i++) begin
          ang = 1.5707963267948966 * (real'(i) + 0.5) / real'(2**TABLE);
          r_mem[i] = BITSIZE'(longint'($floor(amp * $sin(ang) + 0.5)));
        end
      end

      always_ff @(posedge clk) begin
        data <= r_mem[addr];
      end
    end
  endgenerate

endmodule

// File: rtl/sine_nco.sv
// Sine NCO: phase accumulator -> quarter-table lookup with mirroring -> sign -> gain.
// Strobe at cycle N produces a one-cycle valid with the new sample at N+4.
module sine_nco
  import nco_pkg::*;
#(
  parameter int BITSIZE    = BITSIZE_D,
  parameter int PHASE      = PHASE_D,
  parameter int TABLE      = TABLE_D,
  parameter int GAIN_W     = GAIN_W_D,
  parameter     TABLE_FILE = "testtable.hex",
  parameter bit RAMP_TABLE = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               strobe,
  input  logic [PHASE-1:0]   step,
  input  logic               phase_clr,
  input  logic [GAIN_W:0]    gain,
  output logic [BITSIZE-1:0] sample,
  output logic               valid
);

  localparam int IDX_HI = idx_msb(PHASE);
  localparam int IDX_LO = idx_lsb(PHASE, TABLE);
  localparam int PW     = BITSIZE + GAIN_W + 1;
  localparam logic [GAIN_W:0] LP_UNITY = {1'b1, {GAIN_W{1'b0}}};

  logic [PHASE-1:0]          r_phase;
  logic [PHASE-1:0]          w_p_used;
  logic [PHASE-1:0]          w_unused_phase;
  logic [TABLE-1:0]          w_raw;
  logic [TABLE-1:0]          w_idx;

  logic                      r_v1, r_v2, r_v3;
  logic [TABLE-1:0]          r_idx;
  logic                      r_sign1, r_sign2;
  logic [BITSIZE-1:0]        w_mag;
  logic signed [BITSIZE-1:0] r_s3;

  logic [GAIN_W:0]           w_gain_sat;
  logic signed [PW-1:0]      w_s_ext;
  logic signed [PW-1:0]      w_g_ext;
  logic signed [PW-1:0]      w_prod;
  logic signed [PW-1:0]      w_unused_prod;

  assign w_p_used       = phase_clr ? '0 : r_phase;
  assign w_unused_phase = w_p_used;
  assign w_raw          = w_p_used[IDX_HI:IDX_LO];
  // Odd quadrants read the table backwards so the quarter wave mirrors.
  assign w_idx          = w_p_used[PHASE-2] ? ~w_raw : w_raw;

  quarter_rom #(
    .TABLE      (TABLE),
    .BITSIZE    (BITSIZE),
    .TABLE_FILE (TABLE_FILE),
    .RAMP_TABLE (RAMP_TABLE)
  ) u_rom (
    .clk  (clk),
    .addr (r_idx),
    .data (w_mag)
  );

  assign w_gain_sat    = (gain > LP_UNITY) ? LP_UNITY : gain;
  assign w_s_ext       = {{(GAIN_W + 1){r_s3[BITSIZE-1]}}, r_s3};
  assign w_g_ext       = {{BITSIZE{1'b0}}, w_gain_sat};
  assign w_prod        = w_s_ext * w_g_ext;
  assign w_unused_prod = w_prod;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_phase <= '0;
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_v3    <= 1'b0;
      r_idx   <= '0;
      r_sign1 <= 1'b0;
      r_sign2 <= 1'b0;
      r_s3    <= '0;
      sample  <= '0;
      valid   <= 1'b0;
    end else begin
      if (strobe) begin
        r_phase <= w_p_used + step;
      end
      r_v1    <= strobe;
      r_idx   <= w_idx;
      r_sign1 <= w_p_used[PHASE-1];

      r_v2    <= r_v1;
      r_sign2 <= r_sign1;

      r_v3    <= r_v2;
      r_s3    <= r_sign2 ? -w_mag : w_mag;

      valid   <= r_v3;
      // Slicing above the fraction bits is the arithmetic shift right by GAIN_W.
      if (r_v3) begin
        sample <= w_prod[BITSIZE+GAIN_W-1:GAIN_W];
      end
    end
  end

endmodule

// File: tb/tb_sine_nco.sv
// Directed-vector bench for sine_nco with the built-in ramp table (entry i = i).
module tb_sine_nco;

  logic        clk = 1'b0;
  logic        reset;
  logic        strobe;
  logic [15:0] step;
  logic        phase_clr;
  logic [8:0]  gain;
  logic [23:0] sample;
  logic        valid;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sine_nco #(
    .BITSIZE    (24),
    .PHASE      (16),
    .TABLE      (9),
    .GAIN_W     (8),
    .TABLE_FILE ("testtable.hex"),
    .RAMP_TABLE (1'b1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .strobe    (strobe),
    .step      (step),
    .phase_clr (phase_clr),
    .gain      (gain),
    .sample    (sample),
    .valid     (valid)
  );

  typedef struct {
    logic [15:0] step;
    logic        clr;
    logic [8:0]  gain;
    logic [23:0] exp;
  } vec_t;

  localparam int NVEC = 17;
  vec_t tbl [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One strobe; waits (bounded) for the valid, checks latency and returns the sample.
  task automatic strobe_get(input logic [15:0] st, input logic clr, input logic [8:0] g,
                            output logic [23:0] smp);
    int lat;
    bit seen;
    @(posedge clk); #1;
    strobe = 1'b1; step = st; phase_clr = clr; gain = g;
    @(posedge clk); #1;
    strobe = 1'b0; phase_clr = 1'b0;
    lat  = 1;
    seen = 1'b0;
    smp  = 'x;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      lat++;
      if (valid) begin
        seen = 1'b1;
        smp  = sample;
        break;
      end
    end
    if (!seen) begin
      n_checks++;
      n_errors++;
      $display("FAIL valid_timeout: got no valid within 11 cycles, required one at 4");
    end else begin
      chk("latency", lat, 4);
    end
    @(posedge clk); #1;
    chk("valid_one_cycle", {31'b0, valid}, 0);
  endtask

  initial begin
    logic [23:0] s;
    logic [23:0] exp3 [4];
    int bad;

    tbl[0]  = '{16'h4000, 1'b1, 9'd256, 24'h000000};
    tbl[1]  = '{16'h4000, 1'b0, 9'd256, 24'h0001FF};
    tbl[2]  = '{16'h4000, 1'b0, 9'd256, 24'h000000};
    tbl[3]  = '{16'h4000, 1'b0, 9'd256, 24'hFFFE01};
    tbl[4]  = '{16'h4000, 1'b0, 9'd256, 24'h000000};
    tbl[5]  = '{16'h0000, 1'b0, 9'd128, 24'h0000FF};
    tbl[6]  = '{16'h8000, 1'b0, 9'd300, 24'h0001FF};
    tbl[7]  = '{16'h0000, 1'b0, 9'd128, 24'hFFFF00};
    tbl[8]  = '{16'h0000, 1'b0, 9'd0,   24'h000000};
    tbl[9]  = '{16'h5234, 1'b0, 9'd256, 24'hFFFE01};
    tbl[10] = '{16'h0000, 1'b0, 9'd256, 24'h000091};
    tbl[11] = '{16'h0100, 1'b1, 9'd256, 24'h000000};
    tbl[12] = '{16'h3EE0, 1'b0, 9'd256, 24'h000008};
    tbl[13] = '{16'h0020, 1'b0, 9'd256, 24'h0001FF};
    tbl[14] = '{16'h8020, 1'b0, 9'd256, 24'h0001FF};
    tbl[15] = '{16'h0000, 1'b0, 9'd256, 24'hFFFE02};
    tbl[16] = '{16'h0000, 1'b0, 9'd511, 24'hFFFE02};

    reset = 1'b1; strobe = 1'b0; step = '0; phase_clr = 1'b0; gain = 9'd256;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", {31'b0, valid}, 0);
    chk("reset_sample", {8'b0, sample}, 0);
    reset = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      strobe_get(tbl[i].step, tbl[i].clr, tbl[i].gain, s);
      chk($sformatf("vec%0d", i), {8'b0, s}, {8'b0, tbl[i].exp});
    end

    // Back-to-back strobes crossing quadrants: phases 0, 0x4020, 0x8040, 0xC060.
    exp3[0] = 24'h000000; exp3[1] = 24'h0001FE;
    exp3[2] = 24'hFFFFFE; exp3[3] = 24'hFFFE04;
    gain = 9'd256;
    @(posedge clk); #1;
    strobe = 1'b1; phase_clr = 1'b1; step = 16'h4020;
    @(posedge clk); #1; phase_clr = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1; strobe = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      chk($sformatf("b2b_valid%0d", k), {31'b0, valid}, 1);
      chk($sformatf("b2b_sample%0d", k), {8'b0, sample}, {8'b0, exp3[k]});
    end
    @(posedge clk); #1;
    chk("b2b_valid_end", {31'b0, valid}, 0);

    // Reset two cycles after a strobe discards the in-flight sample.
    strobe_get(16'h4000, 1'b1, 9'd256, s);
    strobe_get(16'h0100, 1'b0, 9'd256, s);
    chk("pre_reset_sample", {8'b0, s}, 32'h1FF);
    @(posedge clk); #1; strobe = 1'b1; step = 16'h1000;
    @(posedge clk); #1; strobe = 1'b0;
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (valid) bad++;
      @(posedge clk); #1;
    end
    chk("reset_flush_no_valid", bad, 0);
    chk("reset_flush_sample", {8'b0, sample}, 0);

    // Ramp sweep from phase 0: idx climbs to 511, then mirrors at 0x4000.
    for (int k = 0; k <= 513; k++) begin
      strobe_get(16'h0020, 1'b0, 9'd256, s);
      chk($sformatf("ramp%0d", k), {8'b0, s},
          (k <= 511) ? k : ((k == 512) ? 511 : 510));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
